// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Gathers completed results from NUM_SRC producers into per-source FIFOs
//   and drains up to WB_WIDTH FIFO heads per cycle into registered
//   writeback lanes, using a rotating-priority scan.
//
// Ports
//   clock, reset          rising-edge clock, async active-low reset
//   flush_i               synchronous squash of everything in flight
//   src_valid_i/ready_o   per-source enqueue handshake
//   src_*_i               per-source result fields
//   fu_valid_o, fu_*_o    registered writeback lanes (fields zero when idle)

module wb_arbiter #(
   parameter int XLEN      = 32,
   parameter int PHYS_REGS = 128,
   parameter int ROB_DEPTH = 64,
   parameter int NUM_SRC   = 6,
   parameter int WB_WIDTH  = 4,
   parameter int BUF_DEPTH = 2
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  logic                                          flush_i,
   input  logic [NUM_SRC-1:0]                            src_valid_i,
   input  logic [NUM_SRC-1:0][XLEN-1:0]                  src_value_i,
   input  logic [NUM_SRC-1:0][$clog2(PHYS_REGS)-1:0]     src_dest_prf_i,
   input  logic [NUM_SRC-1:0][$clog2(ROB_DEPTH)-1:0]     src_rob_idx_i,
   input  logic [NUM_SRC-1:0]                            src_exception_i,
   input  logic [NUM_SRC-1:0]                            src_mispred_i,
   output logic [NUM_SRC-1:0]                            src_ready_o,
   output logic [WB_WIDTH-1:0]                           fu_valid_o,
   output logic [WB_WIDTH-1:0][XLEN-1:0]                 fu_value_o,
   output logic [WB_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]    fu_dest_prf_o,
   output logic [WB_WIDTH-1:0][$clog2(ROB_DEPTH)-1:0]    fu_rob_idx_o,
   output logic [WB_WIDTH-1:0]                           fu_exception_o,
   output logic [WB_WIDTH-1:0]                           fu_mispred_o
);

   localparam int TAG_W = $clog2(PHYS_REGS);
   localparam int ROB_W = $clog2(ROB_DEPTH);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SRC_W = $clog2(NUM_SRC);
   localparam int ENT_W = XLEN + TAG_W + ROB_W + 2;

   localparam logic [CNT_W-1:0] FULL     = CNT_W'(BUF_DEPTH);
   localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

   logic [CNT_W-1:0]    count [NUM_SRC];
   logic [PTR_W-1:0]    head  [NUM_SRC];
   logic [PTR_W-1:0]    tail  [NUM_SRC];
   logic [ENT_W-1:0]    mem   [NUM_SRC][BUF_DEPTH];

   logic [SRC_W-1:0]    rr_ptr;
   logic [SRC_W-1:0]    rr_next;
   logic [SRC_W-1:0]    last_src;
   logic [NUM_SRC-1:0]  enq;
   logic [NUM_SRC-1:0]  grant;
   logic [WB_WIDTH-1:0] lane_vld;
   logic [SRC_W-1:0]    lane_src [WB_WIDTH];
   logic [ENT_W-1:0]    lane_ent [WB_WIDTH];

   // Ready looks only at the registered count: a same-cycle dequeue earns no credit.
   always_comb begin
      for (int s = 0; s < NUM_SRC; s++) begin
         src_ready_o[s] = (count[s] < FULL);
         enq[s]         = src_valid_i[s] && src_ready_o[s];
      end
   end

   // Scan from rr_ptr; each non-empty source takes the lowest free lane.
   always_comb begin
      int               idx;
      logic [SRC_W-1:0] s;
      logic             placed;
      idx      = 0;
      s        = '0;
      placed   = 1'b0;
      grant    = '0;
      lane_vld = '0;
      last_src = rr_ptr;
      for (int l = 0; l < WB_WIDTH; l++) begin
         lane_src[l] = '0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_SRC) begin
            idx = idx - NUM_SRC;
         end
         s      = SRC_W'(idx);
         placed = 1'b0;
         if (count[s] != '0) begin
            for (int l = 0; l < WB_WIDTH; l++) begin
               if (!placed && !lane_vld[l]) begin
                  lane_vld[l] = 1'b1;
                  lane_src[l] = s;
                  grant[s]    = 1'b1;
                  last_src    = s;
                  placed      = 1'b1;
               end
            end
         end
      end
      rr_next = (last_src == LAST_SRC) ? '0 : last_src + 1'b1;
   end

   always_comb begin
      for (int l = 0; l < WB_WIDTH; l++) begin
         lane_ent[l] = lane_vld[l] ? mem[lane_src[l]][head[lane_src[l]]] : '0;
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clock) begin
      for (int s = 0; s < NUM_SRC; s++) begin
         if (enq[s] && !flush_i) begin
            mem[s][tail[s]] <= {src_value_i[s], src_dest_prf_i[s], src_rob_idx_i[s],
                                src_exception_i[s], src_mispred_i[s]};
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr         <= '0;
         fu_valid_o     <= '0;
         fu_value_o     <= '0;
         fu_dest_prf_o  <= '0;
         fu_rob_idx_o   <= '0;
         fu_exception_o <= '0;
         fu_mispred_o   <= '0;
         for (int s = 0; s < NUM_SRC; s++) begin
            count[s] <= '0;
            head[s]  <= '0;
            tail[s]  <= '0;
         end
      end else if (flush_i) begin
         rr_ptr         <= '0;
         fu_valid_o     <= '0;
         fu_value_o     <= '0;
         fu_dest_prf_o  <= '0;
         fu_rob_idx_o   <= '0;
         fu_exception_o <= '0;
         fu_mispred_o   <= '0;
         for (int s = 0; s < NUM_SRC; s++) begin
            count[s] <= '0;
            head[s]  <= '0;
            tail[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (enq[s]) begin
               tail[s] <= tail[s] + 1'b1;
            end
            if (grant[s]) begin
               head[s] <= head[s] + 1'b1;
            end
            if (enq[s] && !grant[s]) begin
               count[s] <= count[s] + 1'b1;
            end else if (!enq[s] && grant[s]) begin
               count[s] <= count[s] - 1'b1;
            end
         end
         if (|grant) begin
            rr_ptr <= rr_next;
         end
         fu_valid_o <= lane_vld;
         for (int l = 0; l < WB_WIDTH; l++) begin
            {fu_value_o[l], fu_dest_prf_o[l], fu_rob_idx_o[l],
             fu_exception_o[l], fu_mispred_o[l]} <= lane_ent[l];
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
   localparam int XLEN = 32, PHYS_REGS = 128, ROB_DEPTH = 64;
   localparam int NUM_SRC = 6, WB_WIDTH = 4, BUF_DEPTH = 2;

   logic clock = 1'b0;
   logic reset;
   logic flush_i;
   logic [NUM_SRC-1:0]             src_valid;
   logic [NUM_SRC-1:0][XLEN-1:0]   src_value;
   logic [NUM_SRC-1:0][6:0]        src_prf;
   logic [NUM_SRC-1:0][5:0]        src_rob;
   logic [NUM_SRC-1:0]             src_exc;
   logic [NUM_SRC-1:0]             src_mis;
   logic [NUM_SRC-1:0]             src_ready;
   logic [WB_WIDTH-1:0]            fu_valid;
   logic [WB_WIDTH-1:0][XLEN-1:0]  fu_value;
   logic [WB_WIDTH-1:0][6:0]       fu_prf;
   logic [WB_WIDTH-1:0][5:0]       fu_rob;
   logic [WB_WIDTH-1:0]            fu_exc;
   logic [WB_WIDTH-1:0]            fu_mis;

   always #5 clock = ~clock;

   wb_arbiter #(
      .XLEN(XLEN), .PHYS_REGS(PHYS_REGS), .ROB_DEPTH(ROB_DEPTH),
      .NUM_SRC(NUM_SRC), .WB_WIDTH(WB_WIDTH), .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clock(clock), .reset(reset), .flush_i(flush_i),
      .src_valid_i(src_valid), .src_value_i(src_value), .src_dest_prf_i(src_prf),
      .src_rob_idx_i(src_rob), .src_exception_i(src_exc), .src_mispred_i(src_mis),
      .src_ready_o(src_ready),
      .fu_valid_o(fu_valid), .fu_value_o(fu_value), .fu_dest_prf_o(fu_prf),
      .fu_rob_idx_o(fu_rob), .fu_exception_o(fu_exc), .fu_mispred_o(fu_mis)
   );

   typedef struct {
      int          lane;
      logic [31:0] value;
      logic [6:0]  prf;
      logic [5:0]  rob;
      logic        exc;
      logic        mis;
   } exp_t;

   exp_t sbq[$];
   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input int lane, input logic [31:0] v, input logic [6:0] p,
                       input logic [5:0] r, input logic e, input logic m);
      exp_t x;
      x.lane = lane; x.value = v; x.prf = p; x.rob = r; x.exc = e; x.mis = m;
      sbq.push_back(x);
   endtask

   // Ordinary entries derive prf/rob from the value's low bits.
   task automatic push_v(input int lane, input logic [31:0] v);
      push(lane, v, v[6:0], v[5:0], 1'b0, 1'b0);
   endtask

   task automatic offer(input int s, input logic [31:0] v);
      src_valid[s] = 1'b1;
      src_value[s] = v;
      src_prf[s]   = v[6:0];
      src_rob[s]   = v[5:0];
      src_exc[s]   = 1'b0;
      src_mis[s]   = 1'b0;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Scoreboard monitor: pops one expectation per valid lane, in lane order.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (reset) begin
         for (int l = 0; l < WB_WIDTH; l++) begin
            if (fu_valid[l]) begin
               if (sbq.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_output: lane %0d value %0h, required no output (t=%0t)",
                           l, fu_value[l], $time);
               end else begin
                  e = sbq.pop_front();
                  chk("lane", 64'(l), 64'(e.lane));
                  chk("fields", {fu_value[l], fu_prf[l], fu_rob[l], fu_exc[l], fu_mis[l]},
                      {e.value, e.prf, e.rob, e.exc, e.mis});
               end
            end else begin
               chk("idle_lane_zero", {fu_value[l], fu_prf[l], fu_rob[l], fu_exc[l], fu_mis[l]}, 64'd0);
            end
         end
      end
   end

   initial begin
      reset     = 1'b0;
      flush_i   = 1'b0;
      src_valid = '0;
      src_value = '0;
      src_prf   = '0;
      src_rob   = '0;
      src_exc   = '0;
      src_mis   = '0;
      #12;
      chk("reset_valid", 64'(fu_valid), 64'd0);
      chk("reset_ready", 64'(src_ready), 64'h3f);
      chk("reset_rr", 64'(dut.rr_ptr), 64'd0);
      reset = 1'b1;
      tick;

      // Rotation under contention
      for (int s = 0; s < NUM_SRC; s++) offer(s, 32'h100 + s);
      for (int s = 0; s < 4; s++) push_v(s, 32'h100 + s);
      push_v(0, 32'h104);
      push_v(1, 32'h105);
      tick;
      src_valid = '0;
      tick;
      chk("rot_c1_valid", 64'(fu_valid), 64'hf);
      chk("rot_c1_rr", 64'(dut.rr_ptr), 64'd4);
      tick;
      chk("rot_c2_valid", 64'(fu_valid), 64'h3);
      chk("rot_c2_rr", 64'(dut.rr_ptr), 64'd0);
      tick;
      chk("rot_c3_valid", 64'(fu_valid), 64'h0);

      // Lone grant on source 2 moves rr_ptr to 3
      offer(2, 32'h22);
      push_v(0, 32'h22);
      tick;
      src_valid = '0;
      tick;
      chk("pre_bp_rr", 64'(dut.rr_ptr), 64'd3);

      // Back-pressure on source 2, and enqueue/dequeue at full
      offer(2, 32'hA);
      for (int s = 0; s < NUM_SRC; s++) if (s != 2) offer(s, 32'h40 + s);
      push_v(0, 32'h43); push_v(1, 32'h44); push_v(2, 32'h45); push_v(3, 32'h40);
      push_v(0, 32'h41); push_v(1, 32'hA);  push_v(2, 32'h53); push_v(3, 32'h54);
      push_v(0, 32'h55); push_v(1, 32'h50); push_v(2, 32'h51); push_v(3, 32'hB);
      push_v(0, 32'hC);
      tick;
      chk("bp_ready_e0", 64'(src_ready), 64'h3f);
      offer(2, 32'hB);
      for (int s = 0; s < NUM_SRC; s++) if (s != 2) offer(s, 32'h50 + s);
      tick;
      chk("bp_ready2_full", 64'(src_ready[2]), 64'd0);
      src_valid = '0;
      offer(2, 32'hC);
      tick;
      chk("full_deq_ready2", 64'(src_ready[2]), 64'd1);
      chk("full_deq_count2", 64'(dut.count[2]), 64'd1);
      tick;
      src_valid = '0;
      tick;
      chk("bp_rr_end", 64'(dut.rr_ptr), 64'd3);
      tick;

      // Flush mid-stream: 8 entries buffered, lanes busy
      for (int s = 0; s < NUM_SRC; s++) offer(s, 32'h70 + s);
      push_v(0, 32'h73); push_v(1, 32'h74); push_v(2, 32'h75); push_v(3, 32'h70);
      tick;
      for (int s = 0; s < NUM_SRC; s++) offer(s, 32'h78 + s);
      tick;
      chk("flush_pre_ready", 64'(src_ready), 64'h39);
      src_valid = '0;
      offer(3, 32'hEE);
      flush_i = 1'b1;
      tick;
      flush_i   = 1'b0;
      src_valid = '0;
      chk("flush_valid", 64'(fu_valid), 64'd0);
      chk("flush_ready", 64'(src_ready), 64'h3f);
      chk("flush_rr", 64'(dut.rr_ptr), 64'd0);
      repeat (4) tick;

      // Asynchronous reset while lanes are valid
      for (int s = 0; s < NUM_SRC; s++) offer(s, 32'h90 + s);
      for (int s = 0; s < 4; s++) push_v(s, 32'h90 + s);
      tick;
      src_valid = '0;
      tick;
      chk("ar_pre_valid", 64'(fu_valid), 64'hf);
      #6;
      reset = 1'b0;
      #1;
      chk("ar_valid", 64'(fu_valid), 64'd0);
      chk("ar_value", 64'(fu_value), 64'd0);
      chk("ar_other", 64'({fu_prf, fu_rob, fu_exc, fu_mis}), 64'd0);
      chk("ar_ready", 64'(src_ready), 64'h3f);
      #1;
      reset = 1'b1;
      offer(5, 32'hAB);
      push_v(0, 32'hAB);
      tick;
      src_valid = '0;
      chk("ar_edge1_valid", 64'(fu_valid), 64'd0);
      tick;
      chk("ar_edge2_valid", 64'(fu_valid), 64'd1);
      tick;

      // Field integrity on source 5
      src_valid[5] = 1'b1;
      src_value[5] = 32'hDEADBEEF;
      src_prf[5]   = 7'd127;
      src_rob[5]   = 6'd63;
      src_exc[5]   = 1'b1;
      src_mis[5]   = 1'b1;
      push(0, 32'hDEADBEEF, 7'd127, 6'd63, 1'b1, 1'b1);
      tick;
      src_valid = '0;
      tick;
      chk("field_valid", 64'(fu_valid), 64'd1);
      repeat (2) tick;

      chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
